// File: rtl/spi_fsm_pkg.sv
// Shared types and defaults for the SPI slave transaction controller.
// Optional macro SPI_TRANSACTION_ABORT_EN is consumed by spi_transaction_fsm.
package spi_fsm_pkg;

  localparam int SPI_BYTE_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GET_ADDR   = 3'd1,
    ST_GOT_ADDR   = 3'd2,
    ST_READ_LOAD  = 3'd3,
    ST_READ_SEND  = 3'd4,
    ST_WRITE_GET  = 3'd5,
    ST_WRITE_DONE = 3'd6,
    ST_DONE       = 3'd7
  } spi_state_e;

endpackage

// File: rtl/spi_bit_counter.sv
// Saturating SCLK edge counter; o_terminal flags the increment that completes a byte.
module spi_bit_counter
  import spi_fsm_pkg::*;
#(
  parameter int BYTE_WIDTH = SPI_BYTE_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_terminal
);

  localparam int CW = $clog2(BYTE_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(BYTE_WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(BYTE_WIDTH);

  logic [CW-1:0] r_count;

  // Terminal is combinational so the owner can leave its state on the same edge as the last pulse.
  assign o_terminal = i_inc && (r_count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != FULL)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/spi_transaction_fsm.sv
// Moore controller sequencing an SPI slave address byte then a read or write data byte.
// Define SPI_TRANSACTION_ABORT_EN to add the sticky abortFlag output.
module spi_transaction_fsm
  import spi_fsm_pkg::*;
#(
  parameter int BYTE_WIDTH = SPI_BYTE_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic chipSelect,
  input  logic sclkPosEdge,
  input  logic sclkNegEdge,
  input  logic rwBit,
  output logic srLoad,
  output logic addrLatchEn,
  output logic misoBufEn,
  output logic dmWriteEn,
  output logic busy
`ifdef SPI_TRANSACTION_ABORT_EN
  ,
  output logic abortFlag
`endif
);

  spi_state_e r_state;
  spi_state_e w_next;
  logic       w_clear;
  logic       w_inc;
  logic       w_tc;

  // Only the edge that matters to the current state ever reaches the counter.
  assign w_inc = ((r_state == ST_GET_ADDR || r_state == ST_WRITE_GET) && sclkPosEdge) ||
                 ((r_state == ST_READ_SEND) && sclkNegEdge);

  spi_bit_counter #(.BYTE_WIDTH(BYTE_WIDTH)) u_bit_counter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_inc      (w_inc),
    .o_terminal (w_tc)
  );

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    if (r_state != ST_IDLE && chipSelect) begin
      w_next  = ST_IDLE;
      w_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_clear = 1'b1;
          if (!chipSelect) w_next = ST_GET_ADDR;
        end
        ST_GET_ADDR: if (w_tc) begin
          w_next  = ST_GOT_ADDR;
          w_clear = 1'b1;
        end
        ST_GOT_ADDR:   w_next = rwBit ? ST_READ_LOAD : ST_WRITE_GET;
        ST_READ_LOAD:  w_next = ST_READ_SEND;
        ST_READ_SEND: if (w_tc) begin
          w_next  = ST_DONE;
          w_clear = 1'b1;
        end
        ST_WRITE_GET: if (w_tc) begin
          w_next  = ST_WRITE_DONE;
          w_clear = 1'b1;
        end
        ST_WRITE_DONE: w_next = ST_DONE;
        default:       w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  assign srLoad      = (r_state == ST_READ_LOAD);
  assign addrLatchEn = (r_state == ST_GOT_ADDR);
  assign misoBufEn   = (r_state == ST_READ_SEND);
  assign dmWriteEn   = (r_state == ST_WRITE_DONE);
  assign busy        = (r_state != ST_IDLE);

`ifdef SPI_TRANSACTION_ABORT_EN
  logic r_abort;

  // A chip-select release counts as an abort only while a byte is still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_abort <= 1'b0;
    end else if (r_state == ST_IDLE && !chipSelect) begin
      r_abort <= 1'b0;
    end else if (chipSelect && r_state != ST_IDLE && r_state != ST_DONE) begin
      r_abort <= 1'b1;
    end
  end

  assign abortFlag = r_abort;
`endif

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Directed bench for spi_transaction_fsm (BYTE_WIDTH 8 and 4 instances on shared stimulus).
module tb_spi_transaction_fsm;

  logic clk, reset, chipSelect, sclkPosEdge, sclkNegEdge, rwBit;
  logic sr_load, addr_latch, miso_en, dm_we, busy_o;
  logic sr_load4, addr_latch4, miso_en4, dm_we4, busy4;
`ifdef SPI_TRANSACTION_ABORT_EN
  logic abort_flag, abort_flag4;
`endif

  int checks = 0;
  int errors = 0;
  int en_count = 0;
  int onehot_viol = 0;

  spi_transaction_fsm u_dut (
    .clk(clk), .reset(reset), .chipSelect(chipSelect),
    .sclkPosEdge(sclkPosEdge), .sclkNegEdge(sclkNegEdge), .rwBit(rwBit),
    .srLoad(sr_load), .addrLatchEn(addr_latch), .misoBufEn(miso_en),
    .dmWriteEn(dm_we), .busy(busy_o)
`ifdef SPI_TRANSACTION_ABORT_EN
    , .abortFlag(abort_flag)
`endif
  );

  spi_transaction_fsm #(.BYTE_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .chipSelect(chipSelect),
    .sclkPosEdge(sclkPosEdge), .sclkNegEdge(sclkNegEdge), .rwBit(rwBit),
    .srLoad(sr_load4), .addrLatchEn(addr_latch4), .misoBufEn(miso_en4),
    .dmWriteEn(dm_we4), .busy(busy4)
`ifdef SPI_TRANSACTION_ABORT_EN
    , .abortFlag(abort_flag4)
`endif
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  // Enable monitor on the 8-bit instance
  always @(negedge clk) begin
    if (sr_load | addr_latch | miso_en | dm_we) en_count++;
    if ($countones({sr_load, addr_latch, miso_en, dm_we}) > 1) onehot_viol++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pos_pulse();
    tick();
    sclkPosEdge = 1'b1;
    tick();
    sclkPosEdge = 1'b0;
  endtask

  task automatic neg_pulse();
    tick();
    sclkNegEdge = 1'b1;
    tick();
    sclkNegEdge = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; chipSelect = 1'b1; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; rwBit = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // Scenarios
  task automatic test_reset();
    reset = 1'b1; chipSelect = 1'b0; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; rwBit = 1'b0;
    tick(); tick();
    checks++;
    if ({busy_o, sr_load, addr_latch, miso_en, dm_we} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", {busy_o, sr_load, addr_latch, miso_en, dm_we});
    end
`ifdef SPI_TRANSACTION_ABORT_EN
    checks++;
    if (abort_flag !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", abort_flag); end
`endif
    chipSelect = 1'b1;
    reset = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_cs_high: busy got %b expected 0", busy_o); end
  endtask

  task automatic test_write();
    chipSelect = 1'b0; rwBit = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL write_start_busy: got %b expected 1", busy_o); end
    for (int i = 0; i < 7; i++) pos_pulse();
    checks++;
    if (addr_latch !== 1'b0) begin errors++; $display("FAIL write_addr_early: got %b expected 0", addr_latch); end
    pos_pulse();
    checks++;
    if (addr_latch !== 1'b1) begin errors++; $display("FAIL write_addr_latch: got %b expected 1", addr_latch); end
    tick();
    checks++;
    if ({addr_latch, dm_we, busy_o} !== 3'b001) begin
      errors++; $display("FAIL write_get_entry: {al,we,busy} got %b expected 001", {addr_latch, dm_we, busy_o});
    end
    for (int i = 0; i < 7; i++) pos_pulse();
    checks++;
    if (dm_we !== 1'b0) begin errors++; $display("FAIL write_we_early: got %b expected 0", dm_we); end
    pos_pulse();
    checks++;
    if (dm_we !== 1'b1) begin errors++; $display("FAIL write_we: got %b expected 1", dm_we); end
    tick();
    checks++;
    if ({dm_we, busy_o} !== 2'b01) begin errors++; $display("FAIL write_done: {we,busy} got %b expected 01", {dm_we, busy_o}); end
    pos_pulse(); neg_pulse(); pos_pulse();
    checks++;
    if ({busy_o, sr_load, addr_latch, miso_en, dm_we} !== 5'b10000) begin
      errors++; $display("FAIL write_done_hold: got %b expected 10000", {busy_o, sr_load, addr_latch, miso_en, dm_we});
    end
    chipSelect = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL write_cs_release: busy got %b expected 0", busy_o); end
  endtask

  task automatic test_read();
    chipSelect = 1'b0; rwBit = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) pos_pulse();
    checks++;
    if ({addr_latch, sr_load, miso_en} !== 3'b100) begin
      errors++; $display("FAIL read_cycle_n: {al,ld,miso} got %b expected 100", {addr_latch, sr_load, miso_en});
    end
    tick();
    checks++;
    if ({addr_latch, sr_load, miso_en} !== 3'b010) begin
      errors++; $display("FAIL read_cycle_n1: {al,ld,miso} got %b expected 010", {addr_latch, sr_load, miso_en});
    end
    tick();
    checks++;
    if ({addr_latch, sr_load, miso_en} !== 3'b001) begin
      errors++; $display("FAIL read_cycle_n2: {al,ld,miso} got %b expected 001", {addr_latch, sr_load, miso_en});
    end
    for (int i = 0; i < 7; i++) neg_pulse();
    checks++;
    if (miso_en !== 1'b1) begin errors++; $display("FAIL read_miso_7: got %b expected 1", miso_en); end
    neg_pulse();
    checks++;
    if ({miso_en, busy_o} !== 2'b01) begin errors++; $display("FAIL read_done: {miso,busy} got %b expected 01", {miso_en, busy_o}); end
    chipSelect = 1'b1;
    tick();
  endtask

  task automatic test_abort();
    int snap;
    snap = en_count;
    chipSelect = 1'b0; rwBit = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) pos_pulse();
    chipSelect = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b expected 0", busy_o); end
    tick();
    checks++;
    if (en_count !== snap) begin errors++; $display("FAIL abort_no_enable: enable cycles got %0d expected %0d", en_count, snap); end
`ifdef SPI_TRANSACTION_ABORT_EN
    checks++;
    if (abort_flag !== 1'b1) begin errors++; $display("FAIL abort_flag_set: got %b expected 1", abort_flag); end
`endif
    chipSelect = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL abort_restart: busy got %b expected 1", busy_o); end
`ifdef SPI_TRANSACTION_ABORT_EN
    checks++;
    if (abort_flag !== 1'b0) begin errors++; $display("FAIL abort_flag_clear: got %b expected 0", abort_flag); end
`endif
    // Abort while the one-cycle GOT_ADDR state is pending: latch still fires that cycle.
    for (int i = 0; i < 8; i++) pos_pulse();
    chipSelect = 1'b1;
    #1;
    checks++;
    if (addr_latch !== 1'b1) begin errors++; $display("FAIL abort_got_addr_latch: got %b expected 1", addr_latch); end
    tick();
    checks++;
    if ({busy_o, addr_latch, dm_we} !== 3'b000) begin
      errors++; $display("FAIL abort_got_addr_idle: {busy,al,we} got %b expected 000", {busy_o, addr_latch, dm_we});
    end
  endtask

  task automatic test_stray_edges();
    chipSelect = 1'b0; rwBit = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) pos_pulse();
    for (int i = 0; i < 3; i++) neg_pulse();
    for (int i = 0; i < 4; i++) pos_pulse();
    checks++;
    if (addr_latch !== 1'b0) begin errors++; $display("FAIL stray_addr_7: got %b expected 0", addr_latch); end
    pos_pulse();
    checks++;
    if (addr_latch !== 1'b1) begin errors++; $display("FAIL stray_addr_8: got %b expected 1", addr_latch); end
    tick(); tick();
    for (int i = 0; i < 3; i++) neg_pulse();
    for (int i = 0; i < 4; i++) pos_pulse();
    tick();
    sclkPosEdge = 1'b1; sclkNegEdge = 1'b1;
    tick();
    sclkPosEdge = 1'b0; sclkNegEdge = 1'b0;
    for (int i = 0; i < 3; i++) neg_pulse();
    checks++;
    if (miso_en !== 1'b1) begin errors++; $display("FAIL stray_miso_7: got %b expected 1", miso_en); end
    neg_pulse();
    checks++;
    if ({miso_en, busy_o} !== 2'b01) begin errors++; $display("FAIL stray_read_done: {miso,busy} got %b expected 01", {miso_en, busy_o}); end
    chipSelect = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    chipSelect = 1'b0; rwBit = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) pos_pulse();
    tick(); tick();
    neg_pulse(); neg_pulse();
    checks++;
    if (miso_en !== 1'b1) begin errors++; $display("FAIL async_pre_miso: got %b expected 1", miso_en); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({miso_en, busy_o} !== 2'b00) begin
      errors++; $display("FAIL async_reset_drop: {miso,busy} got %b expected 00", {miso_en, busy_o});
    end
    chipSelect = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL async_post_idle: busy got %b expected 0", busy_o); end
    chipSelect = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL async_fresh_cs: busy got %b expected 1", busy_o); end
    chipSelect = 1'b1;
    tick();
  endtask

  task automatic test_param_width4();
    do_reset();
    chipSelect = 1'b0; rwBit = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) pos_pulse();
    checks++;
    if (addr_latch4 !== 1'b0) begin errors++; $display("FAIL w4_addr_early: got %b expected 0", addr_latch4); end
    pos_pulse();
    checks++;
    if (addr_latch4 !== 1'b1) begin errors++; $display("FAIL w4_addr_latch: got %b expected 1", addr_latch4); end
    tick();
    for (int i = 0; i < 3; i++) pos_pulse();
    checks++;
    if (dm_we4 !== 1'b0) begin errors++; $display("FAIL w4_we_early: got %b expected 0", dm_we4); end
    pos_pulse();
    checks++;
    if ({dm_we4, addr_latch} !== 2'b11) begin
      errors++; $display("FAIL w4_we_and_w8_addr: {we4,al8} got %b expected 11", {dm_we4, addr_latch});
    end
    tick();
    checks++;
    if ({dm_we4, busy4} !== 2'b01) begin errors++; $display("FAIL w4_done: {we4,busy4} got %b expected 01", {dm_we4, busy4}); end
    chipSelect = 1'b1;
    tick();
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL w4_cs_release: busy4 got %b expected 0", busy4); end
  endtask

  task automatic test_onehot();
    checks++;
    if (onehot_viol !== 0) begin errors++; $display("FAIL onehot_enables: violations got %0d expected 0", onehot_viol); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_stray_edges();
    test_async_reset();
    test_param_width4();
    test_onehot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_transaction_fsm.md
SPI_TRANSACTION_FSM -- requirements
Module: spi_transaction_fsm

Interface
REQ-001 SHALL have parameter BYTE_WIDTH, default 8, giving the bits per address+R/W byte and per data byte (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port chipSelect, input, 1 bit: conditioned SPI CS, active-low.
REQ-005 SHALL have port sclkPosEdge, input, 1 bit: one-clk pulse per SCLK rising edge.
REQ-006 SHALL have port sclkNegEdge, input, 1 bit: one-clk pulse per SCLK falling edge.
REQ-007 SHALL have port rwBit, input, 1 bit: shift register parallelDataOut[0]; 1 = read, 0 = write.
REQ-008 SHALL have port srLoad, output, 1 bit: drives shift register parallelLoad.
REQ-009 SHALL have port addrLatchEn, output, 1 bit: address latch write enable.
REQ-010 SHALL have port misoBufEn, output, 1 bit: MISO tri-state buffer enable.
REQ-011 SHALL have port dmWriteEn, output, 1 bit: data memory write enable.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_GET, WRITE_DONE, DONE.
REQ-014 SHALL decode all outputs from the state register only (Moore); no combinational path from inputs to outputs.
REQ-015 IDLE: chipSelect=0 -> GET_ADDR next cycle, bit counter cleared to 0.
REQ-016 GET_ADDR: each sclkPosEdge increments counter; on the BYTE_WIDTH-th pulse -> GOT_ADDR, counter cleared.
REQ-017 GOT_ADDR: exactly one cycle, addrLatchEn=1; rwBit sampled that cycle: 1 -> READ_LOAD, 0 -> WRITE_GET.
REQ-018 READ_LOAD: exactly one cycle, srLoad=1 -> READ_SEND.
REQ-019 READ_SEND: misoBufEn=1; each sclkNegEdge increments counter; on the BYTE_WIDTH-th pulse -> DONE.
REQ-020 WRITE_GET: each sclkPosEdge increments counter; on the BYTE_WIDTH-th pulse -> WRITE_DONE.
REQ-021 WRITE_DONE: exactly one cycle, dmWriteEn=1 -> DONE.
REQ-022 DONE: all enables 0, busy=1; edges ignored; remains until chipSelect=1.
REQ-023 chipSelect=1 in any non-IDLE state SHALL force IDLE next cycle and clear the counter, overriding all edge pulses; a pending one-cycle state (GOT_ADDR, READ_LOAD, WRITE_DONE) SHALL still assert its output during that cycle.
REQ-024 sclkNegEdge SHALL be ignored outside READ_SEND; sclkPosEdge SHALL be ignored outside GET_ADDR and WRITE_GET; simultaneous pulses SHALL count only the pulse relevant to the current state.
REQ-025 Counter width SHALL be $clog2(BYTE_WIDTH+1) bits; it SHALL never wrap.
REQ-026 At most one of srLoad, addrLatchEn, misoBufEn, dmWriteEn SHALL be high in any cycle.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, counter 0, all outputs 0 (busy=0), regardless of clk, including mid-transaction.
REQ-028 After reset release, a transaction SHALL require a fresh chipSelect falling level seen in IDLE.

Configuration
REQ-029 Macro SPI_TRANSACTION_ABORT_EN, when defined, SHALL add output abortFlag (1 bit): sticky high after chipSelect=1 forces IDLE from GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_GET or WRITE_DONE; cleared by reset or next entry to GET_ADDR.
REQ-030 Without SPI_TRANSACTION_ABORT_EN, abortFlag SHALL not exist and behaviour SHALL be otherwise identical.

Structure
REQ-031 Package spi_fsm_pkg SHALL hold the state enum typedef and the default BYTE_WIDTH constant.
REQ-032 Sub-module spi_bit_counter (clear, increment, terminal-count output at BYTE_WIDTH) SHALL hold the counter.

Verification
REQ-033 Write: CS=0, 8 posedges with rwBit=0 at the 8th, then 8 posedges -> addrLatchEn 1 cycle after 8th edge, dmWriteEn exactly 1 cycle after 16th edge, then DONE until CS=1.
REQ-034 Read: CS=0, 8 posedges with rwBit=1 -> addrLatchEn cycle N, srLoad cycle N+1, misoBufEn from N+2 until 8th negedge, then 0.
REQ-035 Abort: CS=1 after 5 address posedges -> IDLE next cycle, no enable ever asserted, abortFlag=1 when macro defined.
REQ-036 Async reset asserted mid-READ_SEND between clk edges -> misoBufEn and busy fall without a clk edge; IDLE after release.
REQ-037 Stray edges: 3 negedges during GET_ADDR and 4 posedges during READ_SEND -> counts unchanged, read completes after exactly 8 negedges.
REQ-038 Parameter: BYTE_WIDTH=4 -> addrLatchEn after 4th posedge, dmWriteEn after 8th posedge.
